param_stack: RTL and testbench
==============================

// Module: param_stack
// PURPOSE
//  Parametrised LIFO stack; next generation of the fixed 16-bit stack. Adds configurable width/depth,
//  full/empty/count status, simultaneous push+pop (replace top), synchronous clear and sticky
//  overflow/underflow errors. Sits beside the datapath as an operand/return-address store.
// PARAMETERS
//  WIDTH   16  data word width in bits
//  DEPTH   8   number of entries (>=2, power of two not required)
//  CNT_W   $clog2(DEPTH+1)  width of occupancy count (derived localparam, not overridable)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-low reset (asserted when 0)
//  push       in   1       write value_in as new top
//  pop        in   1       remove top entry
//  clear      in   1       synchronous flush to empty; error flags also cleared
//  value_in   in   WIDTH   data to push
//  value_out  out  WIDTH   current top of stack (0 when empty)
//  count      out  CNT_W   number of valid entries
//  empty      out  1       count == 0
//  full       out  1       count == DEPTH
//  overflow   out  1       sticky: push attempted while full (without pop)
//  underflow  out  1       sticky: pop attempted while empty
// BEHAVIOUR
//  - All state updates on rising clk; reset sampled only at the edge.
//  - Reset (reset==0): count=0, empty=1, full=0, overflow=0, underflow=0, value_out=0.
//    Memory contents are not reset; they are unobservable because value_out is forced to 0 when empty.
//  - Priority per edge: reset > clear > push/pop.
//  - Op decode (push,pop):
//    00 idle: no change.
//    10 push: if !full, mem[count]<=value_in, count+1. If full: no write, count held, overflow<=1.
//    01 pop:  if !empty, count-1. If empty: count held, underflow<=1.
//    11 replace: if !empty, mem[count-1]<=value_in, count held. If empty: behaves as a push
//       (mem[0]<=value_in, count=1). Never sets an error flag.
//  - value_out = mem[count-1] when count!=0, else 0. It is a combinational read of the registered
//    state, so a push/pop at edge N is visible on value_out in the cycle after edge N (1-cycle latency).
//  - empty, full and count are derived from the registered count and update with it.
//  - Error flags are sticky until reset or clear. Pushing when full or popping when empty leaves
//    memory and count untouched.
//  - clear and reset mid-sequence discard all entries immediately; the next push lands at mem[0].
//  - Inputs are sampled only at the edge. X on value_in is stored as-is; X on push/pop/clear is
//    illegal after reset.
// STRUCTURE
//  - stack_defs.vh: op encoding constants (OP_IDLE=2'b00, OP_POP=2'b01, OP_PUSH=2'b10,
//    OP_REPL=2'b11) and default WIDTH/DEPTH defines, shared with the testbench and future stack variants.
//  - Sub-module stack_regfile (WIDTH, DEPTH): single write port (we, waddr, wdata) and one async read
//    port (raddr, rdata). It contains no reset.
//  - param_stack holds the count register, error flags, op decode and address generation. Write
//    address = push-only ? count : count-1 (0 when empty). Read address = count-1.
// TESTING  (WIDTH=16, DEPTH=8, clk period 10 ns, reset low for the first 2 edges)
//  1. Reset: hold reset=0 for 2 edges -> count=0, empty=1, full=0, value_out=0, overflow=underflow=0.
//  2. Push 16'h0013, 16'h00A5, 16'h0012 -> value_out 0013, then 00A5, then 0012 on successive cycles;
//     count=3. Pop x2 -> value_out 00A5, then 0013; count=1.
//  3. Push 8 values 16'h0001..16'h0008 -> full=1, count=8. A 9th push of 16'h0009 -> overflow=1,
//     value_out stays 0008, count stays 8. Pop -> value_out 0007, full=0, overflow stays 1.
//  4. From empty, pop -> underflow=1, count=0, value_out=0. Next, push=pop=1 with 16'h0014 ->
//     count=1, value_out=0014, no new error.
//  5. With count=2 (tops 0013, 00A5), push=pop=1 with 16'h0014 -> count=2, value_out=0014.
//     Pop -> value_out=0013.
//  6. With count=5 and overflow=1, assert clear with push=1 in the same cycle -> count=0, empty=1,
//     overflow=0, value_out=0 (clear wins). Repeat from count=3 with reset=0 instead of clear ->
//     same result.

Source files
------------

// File: rtl/param_stack_pkg.sv
// Shared definitions for the parametrised LIFO stack.
// Op encoding and default geometry used by RTL and bench.
package param_stack_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } op_e;

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: one write port, one async read port.
// No reset; contents are masked by the stack when empty.
module stack_regfile #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack with status, replace-top,
// synchronous clear and sticky overflow/underflow flags.
module param_stack
  import param_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] value_in,
  output logic [WIDTH-1:0] value_out,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  op_e              op;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_m1;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top;
  logic [WIDTH-1:0] rdata;

  assign op     = op_e'({push, pop});
  assign cnt_m1 = cnt_q - 1'b1;
  assign top    = AW'(cnt_m1);
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CNT_W'(DEPTH));

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    we    = 1'b0;
    waddr = top;
    unique case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          we    = 1'b1;
          waddr = AW'(cnt_q);
          cnt_d = cnt_q + 1'b1;
        end
      end
      OP_POP: begin
        if (empty) unf_d = 1'b1;
        else       cnt_d = cnt_m1;
      end
      OP_REPL: begin
        we = 1'b1;
        if (empty) begin
          waddr = '0;
          cnt_d = CNT_W'(1);
        end
      end
      OP_IDLE: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clear) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Suppress the write when the edge is flushing the stack.
  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_rf (
    .clk   (clk),
    .we    (we & reset & ~clear),
    .waddr (waddr),
    .wdata (value_in),
    .raddr (top),
    .rdata (rdata)
  );

  assign value_out = empty ? '0 : rdata;
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_param_stack.sv
// Directed self-checking bench for param_stack
// (WIDTH=16, DEPTH=8).
module tb_param_stack;
  import param_stack_pkg::*;

  localparam int W = 16;
  localparam int D = 8;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          clear = 1'b0;
  logic [W-1:0]  value_in = '0;
  logic [W-1:0]  value_out;
  logic [CW-1:0] count;
  logic          empty, full;
  logic          overflow, underflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  param_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .value_in  (value_in),
    .value_out (value_out),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step(input logic     pu,
                      input logic     po,
                      input logic     cl,
                      input logic     rs,
                      input logic [W-1:0] v);
    push     = pu;
    pop      = po;
    clear    = cl;
    reset    = rs;
    value_in = v;
    @(posedge clk);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    clear = 1'b0;
    reset = 1'b1;
  endtask

  task automatic do_push(input logic [W-1:0] v);
    step(1'b1, 1'b0, 1'b0, 1'b1, v);
  endtask

  task automatic do_pop();
    step(1'b0, 1'b1, 1'b0, 1'b1, '0);
  endtask

  task automatic do_clear();
    step(1'b0, 1'b0, 1'b1, 1'b1, '0);
  endtask

  initial begin
    // 1. reset held for two edges
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_vout", 32'(value_out), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
    reset = 1'b1;

    // 2. basic push / pop ordering
    do_push(16'h0013);
    chk("p1_vout", 32'(value_out), 32'h13);
    chk("p1_empty", 32'(empty), 0);
    do_push(16'h00A5);
    chk("p2_vout", 32'(value_out), 32'hA5);
    do_push(16'h0012);
    chk("p3_vout", 32'(value_out), 32'h12);
    chk("p3_count", 32'(count), 3);
    do_pop();
    chk("q1_vout", 32'(value_out), 32'hA5);
    do_pop();
    chk("q2_vout", 32'(value_out), 32'h13);
    chk("q2_count", 32'(count), 1);

    // 3. fill, overflow, pop back
    do_clear();
    chk("clr_count", 32'(count), 0);
    for (int i = 1; i <= 8; i++) begin
      do_push(W'(i));
      chk("fill_count", 32'(count), 32'(i));
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_vout", 32'(value_out), 8);
    do_push(16'h0009);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_vout", 32'(value_out), 8);
    chk("ovf_count", 32'(count), 8);
    do_pop();
    chk("ovf_pop_vout", 32'(value_out), 7);
    chk("ovf_pop_full", 32'(full), 0);
    chk("ovf_sticky", 32'(overflow), 1);

    // 4. underflow, then replace on empty
    do_clear();
    chk("clr_ovf", 32'(overflow), 0);
    do_pop();
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_count", 32'(count), 0);
    chk("unf_vout", 32'(value_out), 0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0014);
    chk("repe_count", 32'(count), 1);
    chk("repe_vout", 32'(value_out), 32'h14);
    chk("repe_ovf", 32'(overflow), 0);
    chk("repe_unf", 32'(underflow), 1);

    // 5. replace top with two entries
    do_clear();
    do_push(16'h0013);
    do_push(16'h00A5);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0014);
    chk("rep_count", 32'(count), 2);
    chk("rep_vout", 32'(value_out), 32'h14);
    chk("rep_ovf", 32'(overflow), 0);
    chk("rep_unf", 32'(underflow), 0);
    do_pop();
    chk("rep_pop_vout", 32'(value_out), 32'h13);

    // 6. clear and reset beat a same-cycle push
    do_clear();
    for (int i = 0; i < 8; i++) do_push(W'(16'h20 + i));
    do_push(16'h00FF);
    do_pop();
    do_pop();
    do_pop();
    chk("c6_count", 32'(count), 5);
    chk("c6_ovf", 32'(overflow), 1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0055);
    chk("clrw_count", 32'(count), 0);
    chk("clrw_empty", 32'(empty), 1);
    chk("clrw_ovf", 32'(overflow), 0);
    chk("clrw_vout", 32'(value_out), 0);
    do_push(16'h0077);
    chk("clr_next_vout", 32'(value_out), 32'h77);
    chk("clr_next_count", 32'(count), 1);
    do_push(16'h0031);
    do_push(16'h0032);
    chk("r6_count", 32'(count), 3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0066);
    chk("rstw_count", 32'(count), 0);
    chk("rstw_empty", 32'(empty), 1);
    chk("rstw_ovf", 32'(overflow), 0);
    chk("rstw_vout", 32'(value_out), 0);
    do_push(16'h0088);
    chk("rst_next_vout", 32'(value_out), 32'h88);
    do_pop();
    chk("rst_next_pop", 32'(value_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
